// File: rtl/scroll_ctrl.sv
// scroll_ctrl: paces a scrolling message onto the MAX7219 row shift register.
// Each step waits a programmable period, fetches one column byte, shifts it
// into the row, then hands the row to the display writer and waits for it.
module scroll_ctrl #(
  parameter int DIV_W  = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic              loop,
  input  logic [DIV_W-1:0]  period,
  input  logic [ADDR_W-1:0] msg_len,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              sh_en,
  output logic              sh_dir,
  output logic [7:0]        sh_d,
  output logic              upd_req,
  input  logic              upd_ack,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_SHIFT,
    S_UPDATE
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   timer;
  logic [DIV_W-1:0]   period_q;
  logic [ADDR_W-1:0]  len_q;
  logic               dir_q;
  logic               loop_q;
  logic               stop_pend;

  logic [DIV_W-1:0]   start_reload;
  logic [DIV_W-1:0]   step_reload;
  logic               last_col;

  // A period of 0 behaves like 1, so the countdown start is period-1 floored at 0.
  assign start_reload = (period == '0) ? '0 : period - 1'b1;
  assign step_reload  = (period_q == '0) ? '0 : period_q - 1'b1;
  assign last_col     = (rd_addr == len_q - 1'b1);
  assign sh_dir       = dir_q;

  // Sequencer: config latch, period countdown, fetch/shift/update handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      period_q  <= '0;
      len_q     <= '0;
      dir_q     <= 1'b0;
      loop_q    <= 1'b0;
      stop_pend <= 1'b0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      sh_en     <= 1'b0;
      sh_d      <= '0;
      upd_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sh_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          // stop in the same cycle as start wins and keeps us idle
          if (start && !stop) begin
            dir_q     <= dir;
            loop_q    <= loop;
            period_q  <= period;
            len_q     <= msg_len;
            rd_addr   <= '0;
            stop_pend <= 1'b0;
            if (msg_len == '0) begin
              done <= 1'b1;
            end else begin
              timer <= start_reload;
              busy  <= 1'b1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // nothing is in flight here, so stop can abort immediately
          if (stop) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            rd_req <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (stop) stop_pend <= 1'b1;
          if (rd_valid) begin
            sh_d   <= rd_data;
            rd_req <= 1'b0;
            sh_en  <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (stop) stop_pend <= 1'b1;
          upd_req <= 1'b1;
          state   <= S_UPDATE;
        end
        S_UPDATE: begin
          if (upd_ack) begin
            upd_req   <= 1'b0;
            stop_pend <= 1'b0;
            if (stop_pend || stop) begin
              // aborted run: finish quietly, no done pulse
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (!last_col) begin
              rd_addr <= rd_addr + 1'b1;
              timer   <= step_reload;
              state   <= S_WAIT;
            end else if (loop_q) begin
              rd_addr <= '0;
              timer   <= step_reload;
              state   <= S_WAIT;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
